e1_tick_monitor: RTL and testbench

- Parametrised, multi-port successor of the single-port misc tick/button peripheral.
- Counts per-port E1 RX/TX ticks over each USB SOF window (1 ms) and latches the totals at SOF, so firmware can compute frequency error for clock tuning.
- Debounces the user button and raises a reset request on a long press or a keyed register write.
- Sits on the soc_base peripheral wishbone, one slot of wb_cyc, clocked by clk_sys.

---
 rtl/e1_tick_monitor_pkg.sv | 27 ++
 rtl/e1_btn_debounce.sv | 88 ++++++++
 rtl/e1_tick_monitor.sv | 153 +++++++++++++++
 tb/tb_e1_tick_monitor.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/e1_tick_monitor_pkg.sv
// Register map, reset key, CSR layout and state types for the E1 tick monitor.
package e1_tick_monitor_pkg;

  localparam logic [7:0]  ADDR_CSR       = 8'h00;
  localparam logic [7:0]  ADDR_SOF_CNT   = 8'h01;
  localparam logic [7:0]  ADDR_TSTAMP    = 8'h02;
  localparam logic [7:0]  ADDR_PORT_BASE = 8'h10;

  localparam logic [15:0] RST_KEY = 16'hDEAD;

  localparam int unsigned CSR_BTN   = 0;
  localparam int unsigned CSR_PRESS = 1;
  localparam int unsigned CSR_OVR   = 2;
  localparam int unsigned CSR_TSEN  = 3;

  typedef enum logic {
    BTN_RELEASED = 1'b0,
    BTN_PRESSED  = 1'b1
  } btn_state_t;

  typedef enum logic [1:0] {
    LP_IDLE,
    LP_COUNT,
    LP_FIRED
  } lp_state_t;

endpackage

// File: rtl/e1_btn_debounce.sv
// Button synchroniser + debounce with press-edge and one-shot long-press detection.
module e1_btn_debounce #(
  parameter int unsigned DEB_W  = 16,
  parameter int unsigned LONG_W = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pressed,
  output logic press_edge,
  output logic long_press
);
  import e1_tick_monitor_pkg::*;

  logic              sync_q1;
  logic              sync_q2;
  logic              sync_q3;
  logic [DEB_W-1:0]  deb_cnt;
  btn_state_t        deb_state;
  btn_state_t        deb_prev;
  lp_state_t         lp_state;
  lp_state_t         lp_next;
  logic [LONG_W-1:0] lp_cnt;

  // Raw pin is active-low; idle (released) level is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      sync_q3 <= 1'b1;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
      sync_q3 <= sync_q2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt   <= '0;
      deb_state <= BTN_RELEASED;
      deb_prev  <= BTN_RELEASED;
    end else begin
      deb_prev <= deb_state;
      if (sync_q2 != sync_q3) begin
        deb_cnt <= '0;
      end else if (deb_cnt != '1) begin
        deb_cnt <= deb_cnt + 1'b1;
      end
      if (deb_cnt == '1) begin
        deb_state <= sync_q3 ? BTN_RELEASED : BTN_PRESSED;
      end
    end
  end

  assign pressed    = (deb_state == BTN_PRESSED);
  assign press_edge = (deb_state == BTN_PRESSED) && (deb_prev == BTN_RELEASED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lp_state <= LP_IDLE;
      lp_cnt   <= '0;
    end else begin
      lp_state <= lp_next;
      lp_cnt   <= (lp_state == LP_COUNT && pressed) ? lp_cnt + 1'b1 : '0;
    end
  end

  // LP_FIRED holds until release so a single press requests reset only once.
  always_comb begin
    lp_next    = lp_state;
    long_press = 1'b0;
    unique case (lp_state)
      LP_IDLE:  if (pressed) lp_next = LP_COUNT;
      LP_COUNT: begin
        if (!pressed) begin
          lp_next = LP_IDLE;
        end else if (lp_cnt == '1) begin
          lp_next    = LP_FIRED;
          long_press = 1'b1;
        end
      end
      LP_FIRED: if (!pressed) lp_next = LP_IDLE;
      default:  lp_next = LP_IDLE;
    endcase
  end

endmodule

// File: rtl/e1_tick_monitor.sv
// Per-port E1 RX/TX tick counters latched at USB SOF, button/reset-request logic, wishbone slave.
// Optional SOF timestamp register at 0x02 enabled by E1_TICK_MONITOR_TIMESTAMP_EN.
module e1_tick_monitor #(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned DEB_W   = 16,
  parameter int unsigned LONG_W  = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_PORTS-1:0] tick_e1_rx,
  input  logic [N_PORTS-1:0] tick_e1_tx,
  input  logic               tick_usb_sof,
  input  logic               btn,
  output logic               rst_req,
  input  logic [7:0]         wb_addr,
  output logic [31:0]        wb_rdata,
  input  logic [31:0]        wb_wdata,
  input  logic               wb_we,
  input  logic               wb_cyc,
  output logic               wb_ack
);
  import e1_tick_monitor_pkg::*;

  logic [CNT_W-1:0] rx_cnt [N_PORTS];
  logic [CNT_W-1:0] tx_cnt [N_PORTS];
  logic [CNT_W-1:0] rx_lat [N_PORTS];
  logic [CNT_W-1:0] tx_lat [N_PORTS];

  logic [15:0] sof_cnt;
  logic        press_sticky;
  logic        ovr_sticky;
  logic        blk_unread;
  logic        btn_pressed;
  logic        press_edge;
  logic        long_press;
  logic        wb_hit;
  logic        blk_sel;
  logic        blk_rd;
  logic        csr_wr;
  logic        key_hit;
  logic [31:0] rd_mux;
  logic        unused_wdata;

  e1_btn_debounce #(
    .DEB_W  (DEB_W),
    .LONG_W (LONG_W)
  ) u_btn (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn        (btn),
    .pressed    (btn_pressed),
    .press_edge (press_edge),
    .long_press (long_press)
  );

`ifdef E1_TICK_MONITOR_TIMESTAMP_EN
  localparam logic TS_EN = 1'b1;
  logic [31:0] ts_cnt;
  logic [31:0] ts_lat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt <= '0;
      ts_lat <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      if (tick_usb_sof) ts_lat <= ts_cnt;
    end
  end
`else
  localparam logic TS_EN = 1'b0;
`endif

  // A tick coincident with SOF belongs to the new window, so the reload value is the tick itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        rx_cnt[p] <= '0;
        tx_cnt[p] <= '0;
        rx_lat[p] <= '0;
        tx_lat[p] <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        if (tick_usb_sof) begin
          rx_lat[p] <= rx_cnt[p];
          tx_lat[p] <= tx_cnt[p];
          rx_cnt[p] <= CNT_W'(tick_e1_rx[p]);
          tx_cnt[p] <= CNT_W'(tick_e1_tx[p]);
        end else begin
          if (tick_e1_rx[p] && rx_cnt[p] != '1) rx_cnt[p] <= rx_cnt[p] + 1'b1;
          if (tick_e1_tx[p] && tx_cnt[p] != '1) tx_cnt[p] <= tx_cnt[p] + 1'b1;
        end
      end
    end
  end

  assign wb_hit  = wb_cyc && !wb_ack;
  assign blk_sel = (wb_addr[7:2] == ADDR_PORT_BASE[7:2]);
  assign blk_rd  = wb_hit && !wb_we && blk_sel;
  assign csr_wr  = wb_hit && wb_we && (wb_addr == ADDR_CSR);
  assign key_hit = csr_wr && (wb_wdata[31:16] == RST_KEY);
  assign unused_wdata = ^{wb_wdata[15:3], wb_wdata[0]};

  always_comb begin
    rd_mux = '0;
    if (wb_addr == ADDR_CSR) begin
      rd_mux[CSR_BTN]   = btn_pressed;
      rd_mux[CSR_PRESS] = press_sticky;
      rd_mux[CSR_OVR]   = ovr_sticky;
      rd_mux[CSR_TSEN]  = TS_EN;
    end else if (wb_addr == ADDR_SOF_CNT) begin
      rd_mux[15:0] = sof_cnt;
`ifdef E1_TICK_MONITOR_TIMESTAMP_EN
    end else if (wb_addr == ADDR_TSTAMP) begin
      rd_mux = ts_lat;
`endif
    end else if (blk_sel) begin
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        if (wb_addr[1:0] == 2'(p)) rd_mux = {16'(tx_lat[p]), 16'(rx_lat[p])};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack       <= 1'b0;
      wb_rdata     <= '0;
      rst_req      <= 1'b0;
      sof_cnt      <= '0;
      press_sticky <= 1'b0;
      ovr_sticky   <= 1'b0;
      blk_unread   <= 1'b0;
    end else begin
      wb_ack   <= wb_hit;
      wb_rdata <= wb_hit ? rd_mux : '0;
      rst_req  <= key_hit | long_press;
      if (tick_usb_sof) sof_cnt <= sof_cnt + 1'b1;

      if (press_edge) press_sticky <= 1'b1;
      else if (csr_wr && wb_wdata[CSR_PRESS]) press_sticky <= 1'b0;

      // A block read landing on the SOF cycle returned the old latches, so it still counts.
      if (tick_usb_sof && blk_unread && !blk_rd) ovr_sticky <= 1'b1;
      else if (csr_wr && wb_wdata[CSR_OVR]) ovr_sticky <= 1'b0;

      if (tick_usb_sof) blk_unread <= 1'b1;
      else if (blk_rd) blk_unread <= 1'b0;
    end
  end

endmodule

// File: tb/tb_e1_tick_monitor.sv
// Bench for e1_tick_monitor: two instances (16-bit/2-port fast-button, 8-bit/1-port) on shared stimulus.
`timescale 1ns/1ps
module tb_e1_tick_monitor;

  localparam int unsigned NP0 = 2;
  localparam int unsigned CW0 = 16;
  localparam int unsigned NP1 = 1;
  localparam int unsigned CW1 = 8;
`ifdef E1_TICK_MONITOR_TIMESTAMP_EN
  localparam bit TSEN = 1'b1;
`else
  localparam bit TSEN = 1'b0;
`endif
  localparam logic [31:0] CSR_T = TSEN ? 32'h8 : 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  rx = '0;
  logic [1:0]  tx = '0;
  logic        sof = 1'b0;
  logic        btn = 1'b1;
  logic [7:0]  wb_addr = '0;
  logic [31:0] wb_wdata = '0;
  logic        wb_we = 1'b0;
  logic        wb_cyc = 1'b0;
  logic        ack0, ack1, rr0, rr1;
  logic [31:0] rd0, rd1;

  int n_checks = 0;
  int n_err = 0;
  int rst_seen [2] = '{0, 0};

  always #5 clk = ~clk;

  e1_tick_monitor #(.N_PORTS(NP0), .CNT_W(CW0), .DEB_W(4), .LONG_W(6)) dut0 (
    .clk(clk), .rst_n(rst_n), .tick_e1_rx(rx), .tick_e1_tx(tx), .tick_usb_sof(sof),
    .btn(btn), .rst_req(rr0), .wb_addr(wb_addr), .wb_rdata(rd0), .wb_wdata(wb_wdata),
    .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(ack0)
  );

  e1_tick_monitor #(.N_PORTS(NP1), .CNT_W(CW1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tick_e1_rx(rx[0:0]), .tick_e1_tx(tx[0:0]), .tick_usb_sof(sof),
    .btn(btn), .rst_req(rr1), .wb_addr(wb_addr), .wb_rdata(rd1), .wb_wdata(wb_wdata),
    .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(ack1)
  );

  // ---------------- behavioural model ----------------
  int unsigned m_rx [2], m_tx [2], m_lrx [2], m_ltx [2];
  logic [15:0] m_sof = '0;
  logic [31:0] m_cyc = '0, m_ts = '0;
  bit          m_unread = 0, m_ovr = 0, m_ack = 0, m_hit, m_blk;
  bit          m_btn [2] = '{0, 0};
  bit          m_press [2] = '{0, 0};
  logic [31:0] m_rd [2] = '{32'h0, 32'h0};
  int          exp_rst [2] = '{0, 0};

  function automatic logic [15:0] sat(int unsigned v, int unsigned w);
    int unsigned mx;
    mx = (32'd1 << w) - 1;
    return (v > mx) ? 16'(mx) : 16'(v);
  endfunction

  function automatic logic [31:0] reg_val(int d, logic [7:0] a);
    logic [31:0] v;
    int unsigned cw, np, p;
    v  = '0;
    cw = (d == 0) ? CW0 : CW1;
    np = (d == 0) ? NP0 : NP1;
    if (a == 8'h00) v = {28'd0, TSEN, m_ovr, m_press[d], m_btn[d]};
    else if (a == 8'h01) v = {16'd0, m_sof};
    else if (a == 8'h02) v = TSEN ? m_ts : 32'd0;
    else if (a >= 8'h10 && a <= 8'h13) begin
      p = 32'(a) - 32'h10;
      if (p < np) v = {sat(m_ltx[p], cw), sat(m_lrx[p], cw)};
    end
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        m_rx[p] = 0; m_tx[p] = 0; m_lrx[p] = 0; m_ltx[p] = 0;
        m_btn[p] = 0; m_press[p] = 0; m_rd[p] = '0;
      end
      m_sof = '0; m_cyc = '0; m_ts = '0; m_unread = 0; m_ovr = 0; m_ack = 0;
    end else begin
      m_hit = wb_cyc && !m_ack;
      m_blk = m_hit && !wb_we && wb_addr >= 8'h10 && wb_addr <= 8'h13;
      for (int d = 0; d < 2; d++) m_rd[d] = m_hit ? reg_val(d, wb_addr) : '0;
      m_ack = m_hit;
      if (m_hit && wb_we && wb_addr == 8'h00) begin
        if (wb_wdata[1]) begin m_press[0] = 0; m_press[1] = 0; end
        if (wb_wdata[2]) m_ovr = 0;
        if (wb_wdata[31:16] == 16'hDEAD) begin exp_rst[0]++; exp_rst[1]++; end
      end
      if (sof) begin
        if (m_unread && !m_blk) m_ovr = 1;
        m_unread = 1;
        for (int p = 0; p < 2; p++) begin
          m_lrx[p] = m_rx[p]; m_ltx[p] = m_tx[p];
          m_rx[p] = rx[p];    m_tx[p] = tx[p];
        end
        m_sof = m_sof + 16'd1;
        m_ts  = m_cyc;
      end else begin
        if (m_blk) m_unread = 0;
        for (int p = 0; p < 2; p++) begin
          m_rx[p] += rx[p];
          m_tx[p] += tx[p];
        end
      end
      m_cyc = m_cyc + 32'd1;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("ack0", 32'(ack0), 32'(m_ack));
    check("ack1", 32'(ack1), 32'(m_ack));
    check("rdata0", rd0, m_rd[0]);
    check("rdata1", rd1, m_rd[1]);
    if (rr0) rst_seen[0]++;
    if (rr1) rst_seen[1]++;
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [1:0] r, input logic [1:0] t, input logic s);
    rx = r; tx = t; sof = s;
    @(negedge clk);
    rx = '0; tx = '0; sof = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wb_xfer(input logic [7:0] a, input logic we, input logic [31:0] d,
                         input logic [31:0] e0, input logic [31:0] e1, input bit chk,
                         input string nm);
    bit got;
    got = 0;
    wb_addr = a; wb_we = we; wb_wdata = d; wb_cyc = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack0) begin
        got = 1;
        if (chk) begin
          check({nm, "/d0"}, rd0, e0);
          check({nm, "/d1"}, rd1, e1);
        end
        if (we && d[31:16] == 16'hDEAD) begin
          check({nm, "/rst_req0"}, 32'(rr0), 32'd1);
          check({nm, "/rst_req1"}, 32'(rr1), 32'd1);
        end
        break;
      end
    end
    wb_cyc = 1'b0; wb_we = 1'b0; wb_wdata = '0;
    if (!got) check({nm, "/ack_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] e0, input logic [31:0] e1, input string nm);
    wb_xfer(a, 1'b0, 32'd0, e0, e1, 1'b1, nm);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input string nm);
    wb_xfer(a, 1'b1, d, 32'd0, 32'd0, 1'b0, nm);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_rst_req0", 32'(rr0), 32'd0);
    check("reset_rst_req1", 32'(rr1), 32'd0);
    rd(8'h00, CSR_T, CSR_T, "reset_csr");
    rd(8'h01, 32'h0, 32'h0, "reset_sof");
    rd(8'h02, 32'h0, 32'h0, "reset_ts");
    rd(8'h10, 32'h0, 32'h0, "reset_p0");
    rd(8'h11, 32'h0, 32'h0, "reset_p1");
    rd(8'h20, 32'h0, 32'h0, "unmapped");

    // window: 2048 RX, 2050 TX on port 0
    step(2'b00, 2'b00, 1'b1);
    rd(8'h10, 32'h0, 32'h0, "first_window");
    for (int i = 0; i < 2050; i++) step((i < 2048) ? 2'b01 : 2'b00, 2'b01, 1'b0);
    step(2'b00, 2'b00, 1'b1);
    rd(8'h10, 32'h0802_0800, 32'h00FF_00FF, "p0_2048_2050");
    rd(8'h00, CSR_T, CSR_T, "csr_no_ovr");
    rd(8'h01, 32'd2, 32'd2, "sof_cnt2");

    // 300 RX on port 0, then a port-1 tick coincident with SOF
    for (int i = 0; i < 300; i++) step(2'b01, 2'b00, 1'b0);
    step(2'b10, 2'b00, 1'b1);
    rd(8'h10, 32'h0000_012C, 32'h0000_00FF, "p0_300_sat8");
    rd(8'h11, 32'h0, 32'h0, "p1_before");
    idle(5);
    step(2'b00, 2'b00, 1'b1);
    rd(8'h11, 32'h0000_0001, 32'h0, "p1_sof_tick");
    rd(8'h10, 32'h0, 32'h0, "p0_empty");
    rd(8'h00, CSR_T, CSR_T, "csr_no_ovr2");

    // overrun: two SOFs with no block read in between
    step(2'b00, 2'b00, 1'b1);
    idle(3);
    step(2'b00, 2'b00, 1'b1);
    rd(8'h00, CSR_T | 32'h4, CSR_T | 32'h4, "ovr_set");
    wr(8'h00, 32'h4, "ovr_w1c");
    rd(8'h00, CSR_T, CSR_T, "ovr_clr");
    rd(8'h01, 32'd6, 32'd6, "sof_cnt6");

    // button glitch, then long hold
    btn = 1'b0; idle(5); btn = 1'b1; idle(40);
    rd(8'h00, CSR_T, CSR_T, "glitch");
    check("glitch_rst0", 32'(rst_seen[0]), 32'd0);
    btn = 1'b0; idle(200);
    m_btn[0] = 1; m_press[0] = 1; exp_rst[0]++;
    rd(8'h00, CSR_T | 32'h3, CSR_T, "held");
    check("long_rst0", 32'(rst_seen[0]), 32'(exp_rst[0]));
    check("long_rst0_lit", 32'(rst_seen[0]), 32'd1);
    check("long_rst1", 32'(rst_seen[1]), 32'd0);
    btn = 1'b1; idle(40);
    m_btn[0] = 0;
    rd(8'h00, CSR_T | 32'h2, CSR_T, "released");
    wr(8'h00, 32'h2, "press_w1c");
    rd(8'h00, CSR_T, CSR_T, "press_clr");

    // keyed reset request
    wr(8'h00, 32'hDEAD_0000, "key_write");
    idle(2);
    check("key_rst0", 32'(rst_seen[0]), 32'(exp_rst[0]));
    check("key_rst1", 32'(rst_seen[1]), 32'(exp_rst[1]));
    check("key_rst1_lit", 32'(rst_seen[1]), 32'd1);
    wr(8'h00, 32'hBEEF_0000, "bad_key");
    idle(2);
    check("badkey_rst0", 32'(rst_seen[0]), 32'd2);

    // reset during a wishbone read
    wb_addr = 8'h01; wb_we = 1'b0; wb_cyc = 1'b1;
    #3 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_noack", 32'(ack0), 32'd0);
    end
    wb_cyc = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    rd(8'h00, CSR_T, CSR_T, "post_rst_csr");
    rd(8'h01, 32'h0, 32'h0, "post_rst_sof");
    rd(8'h02, 32'h0, 32'h0, "post_rst_ts");
    rd(8'h10, 32'h0, 32'h0, "post_rst_p0");
    rd(8'h11, 32'h0, 32'h0, "post_rst_p1");
    check("final_rst0", 32'(rst_seen[0]), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
